// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for the byte-strobed memory port.
// Takes one load/store at a time from execute. It word-aligns the address,
// builds byte strobes, lane-shifts store data, holds the request until ack,
// then sign/zero-extends load data.
// Optional: define LSU_TIMEOUT_EN to abort a request with no ack after
// TIMEOUT_CYCLES cycles in ISSUE (done_timeout).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : core request (valid/ready, we, size, unsigned, adr, wdata)
//   done_*          : completion pulse, load data, error, timeout
//   mem_*           : memory request (r_v/w_v, adr, data, strobe) and
//                     response (resp, ack)
module lsu_mem_master #(
    parameter int xlen           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_v,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [xlen-1:0] req_adr,
    input  logic [xlen-1:0] req_wdata,
    output logic            done_v,
    output logic [xlen-1:0] done_rdata,
    output logic            done_err,
    output logic            done_timeout,
    output logic            mem_r_v,
    output logic            mem_w_v,
    output logic [xlen-1:0] mem_adr,
    output logic [xlen-1:0] mem_data,
    output logic [3:0]      mem_strobe,
    input  logic [xlen-1:0] mem_resp,
    input  logic            mem_ack
);

    if (xlen != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("lsu_mem_master: unsupported configuration");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t          state;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [1:0]      lane_q;

    logic            illegal;
    logic [3:0]      strobe_n;
    logic [xlen-1:0] sh;
    logic [xlen-1:0] ext;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`else
    assign done_timeout = 1'b0;
`endif

    // Request legality and strobe, decoded from the live request inputs.
    always_comb begin
        illegal  = 1'b0;
        strobe_n = 4'b0000;
        case (req_size)
            2'd0: strobe_n = 4'b0001 << req_adr[1:0];
            2'd1: begin
                strobe_n = 4'b0011 << req_adr[1:0];
                illegal  = req_adr[0];
            end
            2'd2: begin
                strobe_n = 4'b1111;
                illegal  = |req_adr[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Load extract from the latched lane/size/sign of the request in flight.
    always_comb begin
        sh  = mem_resp >> {lane_q, 3'b000};
        ext = sh;
        case (size_q)
            2'd0: ext = {{(xlen-8){sh[7] & ~uns_q}}, sh[7:0]};
            2'd1: ext = {{(xlen-16){sh[15] & ~uns_q}}, sh[15:0]};
            default: ext = sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            done_v     <= 1'b0;
            done_rdata <= '0;
            done_err   <= 1'b0;
            mem_r_v    <= 1'b0;
            mem_w_v    <= 1'b0;
            mem_adr    <= '0;
            mem_data   <= '0;
            mem_strobe <= 4'b0000;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            lane_q     <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            cnt          <= '0;
            done_timeout <= 1'b0;
`endif
        end else begin
            done_v     <= 1'b0;
            done_err   <= 1'b0;
            done_rdata <= '0;
`ifdef LSU_TIMEOUT_EN
            done_timeout <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_v && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        lane_q    <= req_adr[1:0];
                        if (illegal) begin
                            state    <= DONE;
                            done_v   <= 1'b1;
                            done_err <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            mem_r_v    <= !req_we;
                            mem_w_v    <= req_we;
                            mem_adr    <= {req_adr[xlen-1:2], 2'b00};
                            mem_data   <= req_wdata << {req_adr[1:0], 3'b000};
                            mem_strobe <= strobe_n;
`ifdef LSU_TIMEOUT_EN
                            cnt        <= '0;
`endif
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        mem_r_v    <= 1'b0;
                        mem_w_v    <= 1'b0;
                        state      <= DONE;
                        done_v     <= 1'b1;
                        done_rdata <= we_q ? '0 : ext;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        mem_r_v      <= 1'b0;
                        mem_w_v      <= 1'b0;
                        state        <= DONE;
                        done_v       <= 1'b1;
                        done_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Initiator side of the byte-strobed memory request interface: `r_v`/`w_v`, `adr`, `data`, 4-bit strobe, answered with `resp`/`ack`.
- Accepts one load/store at a time from the core's execute stage.
- Per access it:
  - word-aligns the address;
  - generates byte strobes;
  - lane-shifts store data;
  - holds the request until ack;
  - extracts and sign/zero-extends load data.
- Sits between the execute stage and the data memory port.

Parameters:
- `xlen`, 32, data/address width; only 32 supported (4 byte lanes).
- `TIMEOUT_CYCLES`, 64, max cycles waiting for `mem_ack`; used only with `LSU_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_v`  in  1  core request valid.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- `req_unsigned`  in  1  zero-extend load result (LBU/LHU).
- `req_adr`  in  xlen  byte address.
- `req_wdata`  in  xlen  store data, right-aligned.
- `done_v`  out  1  one-cycle completion pulse.
- `done_rdata`  out  xlen  extended load data; 0 for stores and errors.
- `done_err`  out  1  misaligned or illegal-size request; no memory access made.
- `done_timeout`  out  1  ack not seen within `TIMEOUT_CYCLES`.
- `mem_r_v`  out  1  memory read request.
- `mem_w_v`  out  1  memory write request.
- `mem_adr`  out  xlen  word-aligned address: `{req_adr[xlen-1:2], 2'b00}`.
- `mem_data`  out  xlen  lane-shifted store data.
- `mem_strobe`  out  4  byte-lane enables.
- `mem_resp`  in  xlen  read data from memory.
- `mem_ack`  in  1  memory completion.

Behaviour:
- **Reset.** While `rst` is high, every output is 0 except `req_ready`, which is also 0. The FSM goes to IDLE. `req_ready` rises on the first cycle after `rst` falls.
- **FSM states:** IDLE, ISSUE, DONE.
- **IDLE.**
  - `req_ready` = 1.
  - On `req_v`, latch all `req_*` inputs. Set `lane = req_adr[1:0]`.
  - If the request is illegal, go to DONE with `done_err` = 1. Illegal means:
    - `size` = 3; or
    - half with `adr[0]` = 1; or
    - word with `adr[1:0]` != 0.
  - Otherwise go to ISSUE.
- **ISSUE.**
  - `mem_r_v = !we`, `mem_w_v = we`.
  - `mem_adr`, `mem_data` and `mem_strobe` are registered and held stable until `mem_ack` is sampled high.
  - On `mem_ack`:
    - drop `mem_r_v`/`mem_w_v` next cycle;
    - capture `mem_resp`;
    - go to DONE.
  - `mem_ack` seen in IDLE or DONE is ignored, including a stale ack after reset.
- **Strobe.**
  - byte: `4'b0001 << lane`.
  - half: `4'b0011 << lane`.
  - word: `4'b1111`.
  - Loads also drive the strobe, for information only.
- **Store data.** `mem_data = req_wdata << (8*lane)`. Bytes outside the strobe are don't-care but driven deterministically by the shift.
- **Load extract.**
  - `sh = mem_resp >> (8*lane)`.
  - byte: bits [7:0]; half: bits [15:0]; word: all.
  - Sign-extend from the top kept bit unless `req_unsigned` is set. `req_unsigned` is ignored for word.
- **DONE.**
  - `done_v` = 1 for exactly one cycle.
  - `done_rdata` is valid with `done_v`.
  - Return to IDLE.
  - `req_ready` = 0 in ISSUE and DONE.
- **Latency.**
  - Request accepted at cycle T.
  - `mem_*_v` high from T+1.
  - `mem_ack` sampled at cycle A ≥ T+1 gives `done_v` at A+1.
  - A zero-wait memory gives 3 cycles from accept to done.
  - An error request gives `done_v` at T+1.
  - Back-to-back throughput: one access every 3 cycles minimum.
- **Reset mid-operation.** Abort the access, drop `mem_r_v`/`mem_w_v` at once, and produce no `done_v` for the aborted request.

Optional Feature:
- **Macro:** `LSU_TIMEOUT_EN`.
- **When defined:**
  - A counter clears on entry to ISSUE and increments each ISSUE cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, drop the request, go to DONE, and assert `done_v` with `done_timeout` = 1 and `done_rdata` = 0.
- **When undefined:**
  - No counter exists.
  - `done_timeout` is tied to 0.
  - ISSUE waits indefinitely.

Test Plan:
- **Word load, 2-cycle ack.** Load word at 0x100; memory returns 0xDEADBEEF after 2 cycles → `mem_adr` = 0x100, `mem_strobe` = 1111, held stable until ack; `done_rdata` = 0xDEADBEEF, `done_v` one cycle after ack.
- **Byte load, signed and unsigned.** Byte loads at 0x103 with `mem_resp` = 0x80FF1234 → LB gives 0xFFFFFF80; LBU gives 0x00000080; `mem_adr` = 0x100.
- **Half store.** Half store at 0x202 with `wdata` = 0x0000ABCD → `mem_w_v` = 1, `mem_adr` = 0x200, `mem_strobe` = 1100, `mem_data[31:16]` = 0xABCD; `done_rdata` = 0.
- **Misaligned and illegal requests.** Half at 0x101, word at 0x102, size 3 → `mem_r_v`/`mem_w_v` never assert; `done_v` and `done_err` at T+1.
- **Reset and stale ack.** Assert `rst` during ISSUE, then drive `mem_ack` while in IDLE → no `done_v`, `mem_r_v` = 0; the next request completes normally.
- **Timeout (`LSU_TIMEOUT_EN`).** Never ack, `TIMEOUT_CYCLES` = 8 → `done_v` and `done_timeout` exactly 8 ISSUE cycles after `mem_r_v` rises; `req_ready` returns to 1 one cycle later.
